// File: rtl/bit_stream_packer.sv
// Serial-to-parallel packer: gathers valid-qualified bits into WIDTH-bit words,
// emitting each completed (or flushed, zero-padded) word as a one-cycle pulse.
module bit_stream_packer #(
  parameter int unsigned WIDTH     = 16,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     srst_i,
  input  logic                     data_i,
  input  logic                     data_val_i,
  input  logic                     flush_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     data_val_o,
  output logic [$clog2(WIDTH):0]   data_len_o
);

  localparam int unsigned LW = $clog2(WIDTH) + 1;

  logic [LW-1:0]    cnt;
  logic [WIDTH-1:0] word_buf;
  logic [LW-1:0]    n;
  logic [WIDTH-1:0] assembled;
  logic             emit;

  // Output position i holds bit number k of the word; it takes data_i when k == cnt.
  always_comb begin
    n         = cnt + LW'(data_val_i);
    assembled = word_buf;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (data_val_i && (cnt == LW'(LSB_FIRST ? i : WIDTH - 1 - i)))
        assembled[i] = data_i;
    end
    emit = (n == LW'(WIDTH)) || (flush_i && (n != '0));
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      cnt        <= '0;
      word_buf   <= '0;
      data_o     <= '0;
      data_len_o <= '0;
      data_val_o <= 1'b0;
    end else begin
      data_val_o <= emit;
      if (emit) begin
        data_o     <= assembled;
        data_len_o <= n;
        cnt        <= '0;
        word_buf   <= '0;
      end else begin
        cnt        <= n;
        word_buf   <= assembled;
      end
    end
  end

endmodule

// File: tb/tb_bit_stream_packer.sv
// Bench for bit_stream_packer: three instances (LSB-first, MSB-first, WIDTH=1) share
// one input stream; expected pulses are queued when driven and checked on arrival.
module tb_bit_stream_packer;

  typedef struct {
    logic [15:0] data;
    logic [4:0]  len;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        srst, din, dval, flush;
  logic [15:0] d0, d1;
  logic        d2;
  logic        v0, v1, v2;
  logic [4:0]  l0, l1;
  logic [0:0]  l2;

  int   cyc = 0;
  int   total = 0;
  int   passed = 0;
  exp_t q0[$], q1[$], q2[$];
  logic [15:0] last0_data, last1_data;
  logic [4:0]  last0_len, last1_len;

  int          m_cnt;
  logic [15:0] m_word;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bit_stream_packer #(.WIDTH(16), .LSB_FIRST(1'b1)) u0 (
    .clk_i(clk), .srst_i(srst), .data_i(din), .data_val_i(dval), .flush_i(flush),
    .data_o(d0), .data_val_o(v0), .data_len_o(l0));
  bit_stream_packer #(.WIDTH(16), .LSB_FIRST(1'b0)) u1 (
    .clk_i(clk), .srst_i(srst), .data_i(din), .data_val_i(dval), .flush_i(flush),
    .data_o(d1), .data_val_o(v1), .data_len_o(l1));
  bit_stream_packer #(.WIDTH(1), .LSB_FIRST(1'b1)) u2 (
    .clk_i(clk), .srst_i(srst), .data_i(din), .data_val_i(dval), .flush_i(flush),
    .data_o(d2), .data_val_o(v2), .data_len_o(l2));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  function automatic logic [15:0] rev16(input logic [15:0] w);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[15-i] = w[i];
    return r;
  endfunction

  // Reference behaviour: bit k of a word lands at position k (reversed for MSB-first).
  task automatic step(input logic a, input logic d, input logic f, input logic r);
    int   n;
    exp_t e;
    srst = r; dval = a; din = d; flush = f;
    if (r) begin
      m_cnt  = 0;
      m_word = '0;
    end else begin
      n = m_cnt + int'(a);
      if (a) m_word[m_cnt] = d;
      if (n == 16 || (f && n > 0)) begin
        e.data = m_word; e.len = 5'(n); e.due = cyc + 1;
        q0.push_back(e);
        e.data = rev16(m_word);
        q1.push_back(e);
        m_cnt  = 0;
        m_word = '0;
      end else begin
        m_cnt = n;
      end
      if (a) begin
        e.data = {15'd0, d}; e.len = 5'd1; e.due = cyc + 1;
        q2.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [15:0] value, input int nbits, input logic flush_last);
    for (int i = 0; i < nbits; i++)
      step(1'b1, value[i], flush_last && (i == nbits - 1), 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_d0"}, {48'd0, d0}, 64'd0);
    chk({tag, "_l0"}, {59'd0, l0}, 64'd0);
    chk({tag, "_v0"}, {63'd0, v0}, 64'd0);
    chk({tag, "_d1"}, {48'd0, d1}, 64'd0);
    chk({tag, "_v2"}, {62'd0, v2, d2}, 64'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (v0 === 1'b1) begin
      if (q0.size() == 0) chk("u0_unexpected_pulse", 64'd1, 64'd0);
      else begin
        e = q0.pop_front();
        chk("u0_data", {48'd0, d0}, {48'd0, e.data});
        chk("u0_len", {59'd0, l0}, {59'd0, e.len});
        chk("u0_cycle", 64'(cyc), 64'(e.due));
        last0_data = d0; last0_len = l0;
      end
    end
    if (v1 === 1'b1) begin
      if (q1.size() == 0) chk("u1_unexpected_pulse", 64'd1, 64'd0);
      else begin
        e = q1.pop_front();
        chk("u1_data", {48'd0, d1}, {48'd0, e.data});
        chk("u1_len", {59'd0, l1}, {59'd0, e.len});
        chk("u1_cycle", 64'(cyc), 64'(e.due));
        last1_data = d1; last1_len = l1;
      end
    end
    if (v2 === 1'b1) begin
      if (q2.size() == 0) chk("u2_unexpected_pulse", 64'd1, 64'd0);
      else begin
        e = q2.pop_front();
        chk("u2_data", {63'd0, d2}, {48'd0, e.data});
        chk("u2_len", {63'd0, l2}, {59'd0, e.len});
        chk("u2_cycle", 64'(cyc), 64'(e.due));
      end
    end
  end

  initial begin
    int   got;
    logic [15:0] gap_word;
    srst = 1'b1; din = 1'b0; dval = 1'b0; flush = 1'b0;
    m_cnt = 0; m_word = '0;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk_zero("reset");

    // Two back-to-back full words
    send_bits(16'hA5C3, 16, 1'b0);
    send_bits(16'hFFFF, 16, 1'b0);
    idle(2);
    chk("full_last_data", {48'd0, last0_data}, 64'hFFFF);
    chk("full_last_len", {59'd0, last0_len}, 64'd16);

    // Bit order: 1 then fifteen 0s
    send_bits(16'h0001, 16, 1'b0);
    idle(2);
    chk("msb_first_data", {48'd0, last1_data}, 64'h8000);
    chk("lsb_first_data", {48'd0, last0_data}, 64'h0001);

    // Partial flush of 1,0,1,1,1
    send_bits(16'b11101, 5, 1'b1);
    idle(2);
    chk("flush5_data", {48'd0, last0_data}, 64'h001D);
    chk("flush5_len", {59'd0, last0_len}, 64'd5);
    chk("hold_after_pulse", {48'd0, d0}, 64'h001D);
    send_bits(16'h0003, 2, 1'b1);
    idle(2);
    chk("restart_pos0", {48'd0, last0_data}, 64'h0003);

    // Flush with empty word: no pulse, outputs hold
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);
    chk("empty_flush_len_hold", {59'd0, l0}, 64'd2);

    // Flush coincident with the 16th bit
    send_bits(16'h9E71, 16, 1'b1);
    idle(2);
    chk("flush16_len", {59'd0, last0_len}, 64'd16);

    // Flush without data after 3 bits
    send_bits(16'h0005, 3, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    idle(2);
    chk("flush3_len", {59'd0, last0_len}, 64'd3);
    chk("flush3_data", {48'd0, last0_data}, 64'h0005);

    // Gapped input, invalid cycles carry data_i=1
    gap_word = 16'h5A0C;
    got = 0;
    for (int t = 0; t < 200 && got < 16; t++) begin
      if ($urandom_range(1, 0) == 1) begin
        step(1'b1, gap_word[got], 1'b0, 1'b0);
        got++;
      end else begin
        step(1'b0, 1'b1, 1'b0, 1'b0);
      end
    end
    idle(2);
    chk("gap_bits_sent", 64'(got), 64'd16);
    chk("gap_data", {48'd0, last0_data}, 64'h5A0C);

    // Reset mid-word discards partial bits
    send_bits(16'h007F, 7, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk_zero("midreset");
    send_bits(16'h1234, 16, 1'b0);
    idle(2);
    chk("post_reset_data", {48'd0, last0_data}, 64'h1234);
    chk("post_reset_len", {59'd0, last0_len}, 64'd16);

    idle(3);
    chk("q0_drained", 64'(q0.size()), 64'd0);
    chk("q1_drained", 64'(q1.size()), 64'd0);
    chk("q2_drained", 64'(q2.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bit_stream_packer.md
# bit_stream_packer

Serial-to-parallel front end of the bit-population datapath. Collects a stream of single valid-qualified bits into WIDTH-bit words and presents each completed word as a one-cycle valid pulse, directly compatible with the data/valid input of the population-counter stage. A flush input closes a partial word early, zero-pads it and reports how many bits it actually holds.

## Interface

- WIDTH, 16: output word width in bits; legal range 1..64.
- LSB_FIRST, 1: 1 = first received bit lands in data_o[0]; 0 = first received bit lands in data_o[WIDTH-1].

- clk_i  input  1  clock; all logic on the rising edge.
- srst_i  input  1  reset, synchronous and active-high.
- data_i  input  1  serial data bit.
- data_val_i  input  1  data_i valid this cycle.
- flush_i  input  1  close the current word after this cycle's bit, if any.
- data_o  output  WIDTH  packed word.
- data_val_o  output  1  one-cycle pulse: data_o and data_len_o valid.
- data_len_o  output  $clog2(WIDTH)+1  valid bits in data_o, 1..WIDTH.

## Operation

- Internal state: bit counter cnt (0..WIDTH-1, number of bits held), shift/assembly register buf (WIDTH bits).
- No backpressure: the downstream stage accepts every pulse. Input is always accepted.
- Bit placement: accepted bit k of a word (k = 0 first) goes to buf[k] if LSB_FIRST=1, else to buf[WIDTH-1-k].
- Per cycle, with a = data_val_i, f = flush_i, n = cnt + a (bits in word after this cycle):
  - a=1, n=WIDTH: emit word (len WIDTH). Clear cnt and buf. f is irrelevant (word already closed).
  - f=1, 0<n<WIDTH: emit partial word, len = n. Unfilled positions are 0. Clear cnt and buf.
  - f=1, n=0: no-op. No pulse, len unchanged.
  - otherwise: cnt <= n, buf updated with the new bit if a=1. No pulse.
- Emission registers data_o <= assembled word (including this cycle's bit), data_len_o <= n, data_val_o <= 1.
- data_val_o is 0 in every cycle without an emission. data_o and data_len_o hold their last emitted values between pulses.
- data_i is ignored when data_val_i=0.
- WIDTH=1: every valid bit emits a word of len 1. flush_i has no observable effect.
- Widths: cnt is $clog2(WIDTH)+1 bits internally so that n=WIDTH is representable. data_len_o is never 0 on a pulse.

## Timing

- Latency: 1 cycle. The word is visible the cycle after the clock edge on which its last bit (or flush) is sampled.
- Throughput: one bit per cycle, sustained indefinitely. Consecutive pulses are possible (WIDTH=1, or a flush on the cycle after a full word). Each pulse is independent.
- Flush and a completing bit in the same cycle produce exactly one pulse.
- Reset values: data_o = 0, data_len_o = 0, data_val_o = 0, cnt = 0, buf = 0.
- srst_i dominates all inputs. A partially assembled word is discarded with no pulse. A pulse scheduled for the cycle after reset is suppressed.
- The first bit is accepted on the first cycle with srst_i low.

## Test plan

- Full words, WIDTH=16, LSB_FIRST=1: stream the 16 bits of 0xA5C3 LSB first, then 16 bits of 0xFFFF with no gaps.
  - Response: pulse with data_o=0xA5C3, len=16, exactly 16 cycles later a second pulse with 0xFFFF, len=16. data_val_o is low in between.
- Bit order, LSB_FIRST=0: send 1 followed by fifteen 0s.
  - Response: data_o=0x8000, len=16.
- Partial flush: 5 bits 1,0,1,1,1 with flush_i asserted on the 5th bit.
  - Response: data_o=0x001D, len=5.
  - Next word starts at bit position 0.
- Flush corner cases:
  - flush_i alone with cnt=0: no pulse.
  - flush_i on the cycle of the 16th bit: exactly one pulse, len=16.
  - flush_i with data_val_i=0 after 3 bits: pulse, len=3.
- Gapped input: 16 valid bits with data_val_i toggling randomly and data_i driven to 1 on invalid cycles.
  - Response: the word contains only the valid bits.
- Reset mid-word: 7 bits loaded, then srst_i for 1 cycle, then 16 bits of 0x1234.
  - Response: no pulse for the discarded bits, outputs read 0 after reset, then one pulse with 0x1234, len=16.
